// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory arbiter.
// State encoding, port ids and MMIO decode constants.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic port_t;

  localparam port_t PORT_C = 1'b0;
  localparam port_t PORT_L = 1'b1;

  localparam int MMIO_BIT  = 31;
  localparam int LED_WIDTH = 8;

endpackage

// File: rtl/data_mem_arbiter_arb2_pick.sv
// Two-way grant picker: round-robin on a tie by default,
// C-first fixed priority when DATA_MEM_ARB_FIXED_PRIO_EN is defined.
module arb2_pick
  import data_mem_pkg::*;
(
  input  logic  elig_c,
  input  logic  elig_l,
  input  port_t last_grant,
  output logic  grant_valid,
  output port_t grant_id
);

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // Pick a winner among the eligible ports
  always_comb begin
    grant_valid = elig_c | elig_l;
    grant_id    = PORT_C;
    unique case (1'b1)
      (elig_c & elig_l): begin
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
        grant_id = PORT_C;
`else
        grant_id = ~last_grant;
`endif
      end
      (elig_l & ~elig_c): grant_id = PORT_L;
      default:            grant_id = PORT_C;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the data RAM between CPU (C) and loader (L), decodes bit-31 MMIO
// to an LED register. Option macro: DATA_MEM_ARB_FIXED_PRIO_EN.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_25mhz,
  input  logic                  reset,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [31:0]           c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_ack,
  output logic [DATA_WIDTH-1:0] c_rdata,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [31:0]           l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_ack,
  output logic [DATA_WIDTH-1:0] l_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [LED_WIDTH-1:0]  led
);

  state_t                state;
  port_t                 last_grant;
  port_t                 cur_port;
  logic                  cur_we;
  logic                  cur_mmio;
  logic                  ram_en_q;
  logic                  ram_we_q;

  logic                  elig_c;
  logic                  elig_l;
  logic                  grant_valid;
  port_t                 grant_id;

  logic                  sel_we;
  logic [31:0]           sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  unused_addr;

  assign elig_c = c_req & ~c_ack;
  assign elig_l = l_req & ~l_ack;

  arb2_pick u_pick (
    .elig_c      (elig_c),
    .elig_l      (elig_l),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign sel_we    = (grant_id == PORT_L) ? l_we    : c_we;
  assign sel_addr  = (grant_id == PORT_L) ? l_addr  : c_addr;
  assign sel_wdata = (grant_id == PORT_L) ? l_wdata : c_wdata;

  // Middle address bits alias onto the RAM index
  assign unused_addr = ^sel_addr[MMIO_BIT-1:ADDR_WIDTH];

  // Read result: LED register for MMIO, RAM output otherwise
  assign rd_val = cur_mmio
    ? {{(DATA_WIDTH-LED_WIDTH){1'b0}}, led}
    : ram_rdata;

  // Reset kills an in-flight strobe so an aborted access never writes
  assign ram_en = ram_en_q & ~reset;
  assign ram_we = ram_we_q & ~reset;

  // Arbitration FSM with latched request fields and registered outputs
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= PORT_L;
      cur_port   <= PORT_C;
      cur_we     <= 1'b0;
      cur_mmio   <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      c_ack      <= 1'b0;
      l_ack      <= 1'b0;
      c_rdata    <= '0;
      l_rdata    <= '0;
      led        <= '0;
    end else begin
      c_ack <= 1'b0;
      l_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            cur_port   <= grant_id;
            last_grant <= grant_id;
            cur_we     <= sel_we;
            cur_mmio   <= sel_addr[MMIO_BIT];
            ram_addr   <= sel_addr[ADDR_WIDTH-1:0];
            ram_wdata  <= sel_wdata;
            ram_en_q   <= ~sel_addr[MMIO_BIT];
            ram_we_q   <= sel_we & ~sel_addr[MMIO_BIT];
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
          if (cur_mmio && cur_we) begin
            led <= ram_wdata[LED_WIDTH-1:0];
          end
          state <= RESP;
        end
        RESP: begin
          if (cur_port == PORT_L) begin
            l_ack <= 1'b1;
            if (!cur_we) l_rdata <= rd_val;
          end else begin
            c_ack <= 1'b1;
            if (!cur_we) c_rdata <= rd_val;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter with a behavioural RAM
// and an address-level reference model of memory and LED contents.
module tb_data_mem_arbiter;

  logic        clk_25mhz = 1'b0;
  logic        reset;
  logic        c_req, c_we, l_req, l_we;
  logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
  logic        c_ack, l_ack;
  logic [31:0] c_rdata, l_rdata;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [7:0]  led;

  data_mem_arbiter dut (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .c_req     (c_req),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_ack     (c_ack),
    .c_rdata   (c_rdata),
    .l_req     (l_req),
    .l_we      (l_we),
    .l_addr    (l_addr),
    .l_wdata   (l_wdata),
    .l_ack     (l_ack),
    .l_rdata   (l_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .led       (led)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  // Synchronous single-port RAM attached to the arbiter
  logic [31:0] mem [256];
  always @(posedge clk_25mhz) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  // Strobe activity observed on the RAM side
  int         en_cnt = 0;
  int         we_cnt = 0;
  logic [7:0] last_we_addr = '0;
  always @(negedge clk_25mhz) begin
    if (ram_en) en_cnt++;
    if (ram_we) begin
      we_cnt++;
      last_we_addr = ram_addr;
    end
  end

  // Reference model: word memory indexed by address mod 256, plus LED byte
  logic [31:0] ref_mem [256];
  logic [7:0]  ref_led;

  int vecs = 0;
  int errs = 0;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31]) return {24'h0, ref_led};
    return ref_mem[a % 256];
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
    if (a[31]) ref_led = d[7:0];
    else ref_mem[a % 256] = d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_25mhz);
    #1;
  endtask

  task automatic wait_ack(input int p, output int n);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      n++;
      if ((p == 0) ? c_ack : l_ack) break;
    end
  endtask

  task automatic xfer(input string tag, input int p, input logic we,
                      input logic [31:0] a, input logic [31:0] d);
    int n;
    int en0, we0;
    logic [31:0] exp;
    exp = model_read(a);
    en0 = en_cnt;
    we0 = we_cnt;
    if (p == 0) begin
      c_we = we; c_addr = a; c_wdata = d; c_req = 1'b1;
    end else begin
      l_we = we; l_addr = a; l_wdata = d; l_req = 1'b1;
    end
    wait_ack(p, n);
    check({tag, "_lat"}, n, 3);
    if (!we) check({tag, "_rdata"}, (p == 0) ? c_rdata : l_rdata, exp);
    if (we) model_write(a, d);
    if (a[31]) begin
      check({tag, "_mmio_no_en"}, en_cnt - en0, 0);
      check({tag, "_led"}, {24'h0, led}, {24'h0, ref_led});
    end else if (we) begin
      check({tag, "_we_pulses"}, we_cnt - we0, 1);
      check({tag, "_we_addr"}, {24'h0, last_we_addr}, a % 256);
    end
    if (p == 0) c_req = 1'b0; else l_req = 1'b0;
    tick();
  endtask

  initial begin
    int n, cc, lc, seen_c;
    int order[$];
    logic [31:0] d;
    logic [31:0] a;
    int p;
    logic we;

    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    ref_led = '0;
    ram_rdata = '0;
    reset = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
    repeat (3) tick();

    check("rst_c_ack", c_ack, 0);
    check("rst_l_ack", l_ack, 0);
    check("rst_c_rdata", c_rdata, 0);
    check("rst_l_rdata", l_rdata, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_led", led, 0);
    reset = 1'b0;
    tick();

    // Tie: both held from the same cycle, four accesses each
    c_we = 1; c_addr = 32'h40; c_wdata = $urandom;
    l_we = 1; l_addr = 32'h50; l_wdata = $urandom;
    c_req = 1; l_req = 1;
    cc = 0; lc = 0;
    for (int k = 0; k < 60 && (cc < 4 || lc < 4); k++) begin
      tick();
      if (c_ack && l_ack) check("tie_both_ack", 1, 0);
      if (c_ack) begin
        order.push_back(0);
        model_write(c_addr, c_wdata);
        cc++;
        if (cc == 4) c_req = 0;
        else begin c_addr = c_addr + 1; c_wdata = $urandom; end
      end
      if (l_ack) begin
        order.push_back(1);
        model_write(l_addr, l_wdata);
        lc++;
        if (lc == 4) l_req = 0;
        else begin l_addr = l_addr + 1; l_wdata = $urandom; end
      end
    end
    c_req = 0; l_req = 0;
    tick();
    check("tie_c_count", cc, 4);
    check("tie_l_count", lc, 4);
    check("tie_len", order.size(), 8);
    for (int i = 0; i < order.size() && i < 8; i++)
      check($sformatf("tie_order%0d", i), order[i], i % 2);
    for (int i = 0; i < 4; i++) begin
      xfer($sformatf("tie_rb_c%0d", i), 0, 0, 32'h40 + i, 0);
      xfer($sformatf("tie_rb_l%0d", i), 1, 0, 32'h50 + i, 0);
    end

    // Directed C write then read
    xfer("c_wr5", 0, 1, 32'h5, 32'hDEADBEEF);
    xfer("c_rd5", 0, 0, 32'h5, 0);

    // MMIO store and load
    xfer("mmio_wr", 0, 1, 32'h8000_0000, 32'h0000_00A5);
    xfer("mmio_rd", 0, 0, 32'h8000_0000, 0);

    // Aliasing of middle address bits
    xfer("alias_wr", 0, 1, 32'h105, 32'h12345678);
    xfer("alias_rd", 1, 0, 32'h5, 0);

    // Ack-cycle rule: C held through its ack cycle, L waiting
    c_we = 0; c_addr = 32'h40; c_req = 1;
    tick();
    l_we = 0; l_addr = 32'h50; l_req = 1;
    wait_ack(0, n);
    check("ackrule_c_lat", n, 2);
    check("ackrule_c_rdata", c_rdata, model_read(32'h40));
    n = 0; seen_c = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      n++;
      if (n == 2) c_req = 0;
      if (c_ack) seen_c++;
      if (l_ack) break;
    end
    check("ackrule_l_lat", n, 3);
    check("ackrule_no_c_regrant", seen_c, 0);
    check("ackrule_l_rdata", l_rdata, model_read(32'h50));
    c_req = 0; l_req = 0;
    tick();

    // Randomised mixed traffic
    for (int i = 0; i < 40; i++) begin
      p  = $urandom_range(0, 1);
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'h8000_0000 | ($urandom & 32'hFF);
      else a = $urandom & 32'h7FFF_FF0F;
      xfer($sformatf("rnd%0d", i), p, we, a, d);
    end

    // Make sure LED is non-zero so the reset check is meaningful
    xfer("pre_rst_led", 1, 1, 32'h8000_0004, 32'h0000_005A);

    // Reset while an L RAM write is in ACCESS
    n = we_cnt;
    l_we = 1; l_addr = 32'h33; l_wdata = 32'hCAFEF00D; l_req = 1;
    tick();
    reset = 1;
    #1;
    check("rst_mid_ram_we", ram_we, 0);
    check("rst_mid_ram_en", ram_en, 0);
    tick();
    reset = 0;
    ref_led = '0;
    check("rst_mid_l_ack", l_ack, 0);
    check("rst_mid_led", led, 0);
    check("rst_mid_no_write", we_cnt - n, 0);
    check("rst_mid_l_rdata", l_rdata, 0);
    wait_ack(1, cc);
    check("rst_retry_lat", cc, 3);
    check("rst_retry_write", we_cnt - n, 1);
    check("rst_retry_addr", last_we_addr, 8'h33);
    model_write(32'h33, 32'hCAFEF00D);
    l_req = 0;
    tick();
    xfer("rst_rb", 0, 0, 32'h33, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout vecs=%0d", vecs);
    $fatal(1, "timeout");
  end

endmodule
